// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM states, default
// geometry and the width helpers used to size counters and ports.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 4;
  localparam int DEF_K_DEPTH = 16;
  localparam int DEF_ACC_W   = 24;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ADDR_W = width_of(DEF_K_DEPTH);
  localparam int DEF_KLEN_W = $clog2(DEF_K_DEPTH) + 1;
  localparam int DEF_IDX_W  = width_of(DEF_ROWS * DEF_COLS);

endpackage

// File: rtl/systolic_drain.sv
// Result drain: snapshots the PE accumulators once per job and streams them
// out row-major over a valid/ready handshake.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              capture,
  input  logic                              active,
  input  logic                              clr,
  input  logic [ROWS*COLS*ACC_W-1:0]        pe_vals,
  input  logic                              res_ready,
  output logic [ACC_W-1:0]                  res_data,
  output logic [width_of(ROWS*COLS)-1:0]    res_idx,
  output logic                              res_valid,
  output logic                              last_xfer
);

  localparam int NUM_PE = ROWS * COLS;
  localparam int IDX_W  = width_of(NUM_PE);

  logic [ACC_W-1:0] snap [NUM_PE];
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             at_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PE; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_PE; i++) snap[i] <= pe_vals[i*ACC_W +: ACC_W];
    end
  end

  assign xfer      = active && res_ready;
  assign at_last   = (idx == IDX_W'(NUM_PE - 1));
  assign last_xfer = xfer && at_last;

  // The index holds while stalled and parks at zero whenever not draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (clr || !active) begin
      idx <= '0;
    end else if (xfer) begin
      idx <= at_last ? '0 : idx + IDX_W'(1);
    end
  end

  assign res_valid = active;
  assign res_idx   = idx;
  assign res_data  = active ? snap[idx] : '0;

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for a ROWS x COLS systolic array: clears the PEs, streams
// k_len SRAM words, waits out the skew, then drains the results.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int K_DEPTH = DEF_K_DEPTH,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [$clog2(K_DEPTH):0]          k_len,
  output logic                              sram_rd_en,
  output logic [$clog2(K_DEPTH)-1:0]        sram_addr,
  output logic                              array_clr,
  output logic                              array_en,
  input  logic [ROWS*COLS*ACC_W-1:0]        pe_vals,
  output logic [ACC_W-1:0]                  res_data,
  output logic [width_of(ROWS*COLS)-1:0]    res_idx,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              busy,
  output logic                              compute_done,
  output logic                              err
);

  localparam int KLEN_W  = $clog2(K_DEPTH) + 1;
  localparam int ADDR_W  = $clog2(K_DEPTH);
  localparam int FLUSH_N = ROWS + COLS;
  localparam int CNT_W   = $clog2((K_DEPTH > FLUSH_N) ? K_DEPTH : FLUSH_N) + 1;

  state_t            state;
  state_t            next_state;
  logic [KLEN_W-1:0] k_reg;
  logic [CNT_W-1:0]  cnt;
  logic              k_ok;
  logic              accept;
  logic              feed_last;
  logic              flush_last;
  logic              capture;
  logic              last_xfer;

  assign k_ok       = (k_len != '0) && (k_len <= KLEN_W'(K_DEPTH));
  assign accept     = (state == S_IDLE) && start && !abort && k_ok;
  assign feed_last  = (state == S_FEED) && (cnt == CNT_W'(k_reg - KLEN_W'(1)));
  assign flush_last = (state == S_FLUSH) && (cnt == CNT_W'(FLUSH_N - 1));
  assign capture    = flush_last && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Abort overrides every transition, including the hop out of DONE.
  always_comb begin
    next_state   = state;
    busy         = (state != S_IDLE);
    array_clr    = 1'b0;
    sram_rd_en   = 1'b0;
    array_en     = 1'b0;
    compute_done = 1'b0;
    case (state)
      S_IDLE:  if (accept) next_state = S_CLEAR;
      S_CLEAR: begin
        array_clr  = 1'b1;
        next_state = S_FEED;
      end
      S_FEED: begin
        sram_rd_en = 1'b1;
        array_en   = 1'b1;
        if (feed_last) next_state = S_FLUSH;
      end
      S_FLUSH: begin
        array_en = 1'b1;
        if (flush_last) next_state = S_DRAIN;
      end
      S_DRAIN: if (last_xfer) next_state = S_DONE;
      S_DONE: begin
        compute_done = !abort;
        next_state   = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  assign sram_addr = sram_rd_en ? cnt[ADDR_W-1:0] : '0;

  // One counter serves both the FEED address and the FLUSH skew wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if ((state == S_FEED || state == S_FLUSH) && !abort && !feed_last && !flush_last) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg <= '0;
      err   <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && !abort && !k_ok;
      if (accept) k_reg <= k_len;
    end
  end

  systolic_drain #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ACC_W (ACC_W)
  ) u_drain (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .active    (state == S_DRAIN),
    .clr       (abort),
    .pe_vals   (pe_vals),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer (4x4 array, K_DEPTH=16) with
// hand-derived cycle timing and result values.
module tb_systolic_sequencer;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K_DEPTH = 16;
  localparam int ACC_W   = 24;
  localparam int N       = ROWS * COLS;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               res_ready = 1'b0;
  logic [4:0]         k_len = '0;
  logic               sram_rd_en;
  logic [3:0]         sram_addr;
  logic               array_clr;
  logic               array_en;
  logic [N*ACC_W-1:0] pe_vals = '0;
  logic [ACC_W-1:0]   res_data;
  logic [3:0]         res_idx;
  logic               res_valid;
  logic               busy;
  logic               compute_done;
  logic               err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_sequencer #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .K_DEPTH (K_DEPTH),
    .ACC_W   (ACC_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .k_len        (k_len),
    .sram_rd_en   (sram_rd_en),
    .sram_addr    (sram_addr),
    .array_clr    (array_clr),
    .array_en     (array_en),
    .pe_vals      (pe_vals),
    .res_data     (res_data),
    .res_idx      (res_idx),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .busy         (busy),
    .compute_done (compute_done),
    .err          (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] k, input logic a);
    start = s;
    k_len = k;
    abort = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PE(i) holds base+i+1, so base 0 gives the 1..16 row-major ramp.
  function automatic logic [N*ACC_W-1:0] pattern(input int base);
    logic [N*ACC_W-1:0] p;
    for (int i = 0; i < N; i++) p[i*ACC_W +: ACC_W] = ACC_W'(base + i + 1);
    return p;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_rd"}, 32'(sram_rd_en), 0);
    checkOutput({tag, "_addr"}, 32'(sram_addr), 0);
    checkOutput({tag, "_en"}, 32'(array_en), 0);
    checkOutput({tag, "_clr"}, 32'(array_clr), 0);
    checkOutput({tag, "_valid"}, 32'(res_valid), 0);
    checkOutput({tag, "_idx"}, 32'(res_idx), 0);
    checkOutput({tag, "_data"}, 32'(res_data), 0);
    checkOutput({tag, "_done"}, 32'(compute_done), 0);
  endtask

  task automatic runJob(input int k);
    int reads = 0;
    int max_addr = 0;
    int got = 0;
    bit done = 0;
    pe_vals   = pattern(0);
    res_ready = 1'b1;
    applyStimulus(1'b1, 5'(k), 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 200 && !done; c++) begin
      if (sram_rd_en) begin
        reads++;
        if (int'(sram_addr) > max_addr) max_addr = int'(sram_addr);
      end
      if (res_valid && res_ready) begin
        checkOutput("job_idx", 32'(res_idx), 32'(got));
        checkOutput("job_data", 32'(res_data), 32'(got + 1));
        got++;
      end
      if (compute_done) done = 1;
      else tick();
    end
    checkOutput("job_reads", 32'(reads), 32'(k));
    checkOutput("job_max_addr", 32'(max_addr), 32'(k - 1));
    checkOutput("job_results", 32'(got), 16);
    checkOutput("job_done", 32'(done), 1);
    tick();
    checkOutput("job_idle", 32'(busy), 0);
  endtask

  initial begin
    int exp_idx;
    bit done;

    // Reset state
    #2;
    checkIdleOutputs("reset");
    checkOutput("reset_err", 32'(err), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Nominal k_len=8 job with full timing and snapshot isolation
    pe_vals   = pattern(100);
    res_ready = 1'b1;
    applyStimulus(1'b1, 5'd8, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("t1_clr", 32'(array_clr), 1);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_clr_rd", 32'(sram_rd_en), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t1_feed_rd", 32'(sram_rd_en), 1);
      checkOutput("t1_feed_addr", 32'(sram_addr), 32'(i));
      checkOutput("t1_feed_en", 32'(array_en), 1);
      checkOutput("t1_feed_clr", 32'(array_clr), 0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t1_flush_rd", 32'(sram_rd_en), 0);
      checkOutput("t1_flush_en", 32'(array_en), 1);
      checkOutput("t1_flush_valid", 32'(res_valid), 0);
      if (i == 7) pe_vals = pattern(0);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) pe_vals = pattern(200);
      checkOutput("t1_drain_valid", 32'(res_valid), 1);
      checkOutput("t1_drain_idx", 32'(res_idx), 32'(i));
      checkOutput("t1_drain_data", 32'(res_data), 32'(i + 1));
      checkOutput("t1_drain_en", 32'(array_en), 0);
      checkOutput("t1_drain_done", 32'(compute_done), 0);
    end
    tick();
    checkOutput("t1_done", 32'(compute_done), 1);
    checkOutput("t1_done_busy", 32'(busy), 1);
    checkOutput("t1_done_valid", 32'(res_valid), 0);
    tick();
    checkOutput("t1_after_done", 32'(compute_done), 0);
    checkOutput("t1_after_busy", 32'(busy), 0);

    // Backpressure: ready toggles every cycle
    pe_vals = pattern(0);
    applyStimulus(1'b1, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    exp_idx = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      res_ready = c[0];
      if (res_valid) begin
        checkOutput("t2_idx", 32'(res_idx), 32'(exp_idx));
        checkOutput("t2_data", 32'(res_data), 32'(exp_idx + 1));
        if (res_ready) exp_idx++;
      end
      if (compute_done) done = 1;
      else tick();
    end
    checkOutput("t2_count", 32'(exp_idx), 16);
    checkOutput("t2_done", 32'(done), 1);
    tick();
    res_ready = 1'b1;

    // Illegal lengths: k_len=0 then k_len=17
    applyStimulus(1'b1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("t3_err0", 32'(err), 1);
    checkOutput("t3_busy0", 32'(busy), 0);
    checkOutput("t3_rd0", 32'(sram_rd_en), 0);
    tick();
    checkOutput("t3_err0_clear", 32'(err), 0);
    applyStimulus(1'b1, 5'd17, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("t3_err17", 32'(err), 1);
    checkOutput("t3_busy17", 32'(busy), 0);
    checkOutput("t3_rd17", 32'(sram_rd_en), 0);
    tick();
    checkOutput("t3_err17_clear", 32'(err), 0);
    checkOutput("t3_busy_after", 32'(busy), 0);

    // Abort and start together in IDLE: abort wins
    applyStimulus(1'b1, 5'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("t4_abort_start_busy", 32'(busy), 0);
    checkOutput("t4_abort_start_err", 32'(err), 0);

    // Abort at the third FEED cycle
    applyStimulus(1'b1, 5'd8, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("t4_third_feed_addr", 32'(sram_addr), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkIdleOutputs("t4_abort");
    tick();
    checkOutput("t4_abort_done", 32'(compute_done), 0);
    checkOutput("t4_abort_stays", 32'(busy), 0);

    // Full-depth job after abort, with an ignored start mid-job
    fork
      runJob(16);
      begin
        tick();
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0);
        checkOutput("t4_busy_start_err", 32'(err), 0);
        checkOutput("t4_busy_start_busy", 32'(busy), 1);
      end
    join

    // Asynchronous reset in the middle of DRAIN
    pe_vals = pattern(0);
    applyStimulus(1'b1, 5'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 50 && !res_valid; c++) tick();
    checkOutput("t5_reached_drain", 32'(res_valid), 1);
    tick();
    tick();
    checkOutput("t5_mid_drain_idx", 32'(res_idx), 2);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("t5_reset");
    checkOutput("t5_reset_err", 32'(err), 0);
    tick();
    reset_n = 1'b1;
    tick();
    runJob(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
